// File: rtl/ss_bus_pkg.sv
// Savestate bus package: bus widths, word type, load payload, scan states and
// the address-window helper shared by every savestate bank.
package ss_bus_pkg;

    localparam int unsigned SS_ADR_W  = 10;
    localparam int unsigned SS_DATA_W = 64;
    localparam int unsigned SS_IDX_W  = 4;   // register number within a bank
    localparam int unsigned SS_CUR_W  = 5;   // scan cursor, one wider so NUM_REGS fits

    typedef logic [SS_DATA_W-1:0] ss_word_t;

    // One register handed back to the owning core module.
    typedef struct packed {
        logic                valid;
        logic [SS_IDX_W-1:0] idx;
        ss_word_t            data;
    } ss_load_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

    // True when base <= adr < base + n; 11-bit compare so the window end cannot wrap.
    function automatic logic ss_hit(
        input logic [SS_ADR_W-1:0] adr,
        input logic [SS_ADR_W-1:0] base,
        input logic [SS_ADR_W:0]   n
    );
        logic [SS_ADR_W:0] adr_x;
        logic [SS_ADR_W:0] base_x;
        adr_x  = {1'b0, adr};
        base_x = {1'b0, base};
        return (adr_x >= base_x) && (adr_x < (base_x + n));
    endfunction

endpackage

// File: rtl/ss_dirty_scan.sv
// Priority encoder for the commit scan: lowest dirty index at or above cursor.
// Ports: dirty (per-register mask), cursor (first index to consider),
//        found_c (a candidate exists), index_c (that candidate).
module ss_dirty_scan
    import ss_bus_pkg::*;
#(
    parameter int unsigned NUM_REGS = 4
) (
    input  logic [NUM_REGS-1:0] dirty,
    input  logic [SS_CUR_W-1:0] cursor,
    output logic                found_c,
    output logic [SS_IDX_W-1:0] index_c
);

    // Walk downwards so the lowest qualifying index is the last one written.
    always_comb begin
        found_c = 1'b0;
        index_c = '0;
        for (int i = int'(NUM_REGS) - 1; i >= 0; i--) begin
            if (dirty[i] && (SS_CUR_W'(i) >= cursor)) begin
                found_c = 1'b1;
                index_c = SS_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ss_reg_bank.sv
// Savestate register bank: NUM_REGS shadow registers at consecutive bus indices
// from BASE_INDEX. Captures live state, takes bus writes, reloads defaults on
// savestate reset, reads back onto the OR-combined bus, and on commit streams
// dirty registers one per cycle to the owning core.
// Ports: clk/reset_n; ss_din/ss_adr/ss_wren/ss_rst/ss_dout savestate bus;
//        live_in/capture snapshot path; commit/busy/load_* commit stream.
module ss_reg_bank
    import ss_bus_pkg::*;
#(
    parameter logic [SS_ADR_W-1:0]           BASE_INDEX = 10'd0,
    parameter int unsigned                   NUM_REGS   = 4,
    parameter logic [NUM_REGS*SS_DATA_W-1:0] DEFAULTS   = '0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [SS_DATA_W-1:0]          ss_din,
    input  logic [SS_ADR_W-1:0]           ss_adr,
    input  logic                          ss_wren,
    input  logic                          ss_rst,
    output logic [SS_DATA_W-1:0]          ss_dout,
    input  logic [NUM_REGS*SS_DATA_W-1:0] live_in,
    input  logic                          capture,
    input  logic                          commit,
    output logic                          busy,
    output logic                          load_valid,
    output logic [SS_IDX_W-1:0]           load_idx,
    output logic [SS_DATA_W-1:0]          load_data
);

    ss_word_t            shadow_q [NUM_REGS];
    ss_word_t            shadow_d [NUM_REGS];
    logic [NUM_REGS-1:0] dirty_q, dirty_d;
    scan_state_e         state_q, state_d;
    logic [SS_CUR_W-1:0] cursor_q, cursor_d;
    ss_word_t            ss_dout_q, ss_dout_d;
    logic                busy_q, busy_d;
    ss_load_t            load_q, load_d;

    logic                hit;
    logic [SS_IDX_W-1:0] local_idx;
    logic                scan_found;
    logic [SS_IDX_W-1:0] scan_idx;

    // Address decode; the offset is truncated, only meaningful when hit is set.
    assign hit       = ss_hit(ss_adr, BASE_INDEX, (SS_ADR_W+1)'(NUM_REGS));
    assign local_idx = SS_IDX_W'(ss_adr - BASE_INDEX);

    ss_dirty_scan #(
        .NUM_REGS (NUM_REGS)
    ) u_scan (
        .dirty   (dirty_q),
        .cursor  (cursor_q),
        .found_c (scan_found),
        .index_c (scan_idx)
    );

    // Next-state: read port, commit scan, then shadow update by priority.
    always_comb begin
        state_d      = state_q;
        cursor_d     = cursor_q;
        busy_d       = busy_q;
        load_d       = load_q;
        load_d.valid = 1'b0;
        dirty_d      = dirty_q;
        shadow_d     = shadow_q;
        ss_dout_d    = '0;

        // Read returns pre-update shadow; same-cycle writes are not forwarded.
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (hit && (local_idx == SS_IDX_W'(i))) begin
                ss_dout_d = shadow_q[i];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (commit) begin
                    state_d  = ST_SCAN;
                    cursor_d = '0;
                    busy_d   = 1'b1;
                end
            end
            ST_SCAN: begin
                if (scan_found) begin
                    load_d.valid = 1'b1;
                    load_d.idx   = scan_idx;
                    for (int i = 0; i < int'(NUM_REGS); i++) begin
                        if (scan_idx == SS_IDX_W'(i)) begin
                            load_d.data = shadow_q[i];
                            dirty_d[i]  = 1'b0;
                        end
                    end
                    cursor_d = SS_CUR_W'(scan_idx) + SS_CUR_W'(1);
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
        endcase

        // Applied after the scan so a same-cycle write re-marks an emitted index.
        if (ss_rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                shadow_d[i] = DEFAULTS[i*SS_DATA_W +: SS_DATA_W];
            end
            dirty_d = '1;
        end else if (capture) begin
            // Snapshot mirrors the core, so nothing needs to be applied back.
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                shadow_d[i] = live_in[i*SS_DATA_W +: SS_DATA_W];
            end
        end else if (ss_wren && hit) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (local_idx == SS_IDX_W'(i)) begin
                    shadow_d[i] = ss_din;
                    dirty_d[i]  = 1'b1;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                shadow_q[i] <= DEFAULTS[i*SS_DATA_W +: SS_DATA_W];
            end
            dirty_q   <= '0;
            state_q   <= ST_IDLE;
            cursor_q  <= '0;
            ss_dout_q <= '0;
            busy_q    <= 1'b0;
            load_q    <= '0;
        end else begin
            shadow_q  <= shadow_d;
            dirty_q   <= dirty_d;
            state_q   <= state_d;
            cursor_q  <= cursor_d;
            ss_dout_q <= ss_dout_d;
            busy_q    <= busy_d;
            load_q    <= load_d;
        end
    end

    assign ss_dout    = ss_dout_q;
    assign busy       = busy_q;
    assign load_valid = load_q.valid;
    assign load_idx   = load_q.idx;
    assign load_data  = load_q.data;

endmodule

// File: tb/tb_ss_reg_bank.sv
// Bench for ss_reg_bank: directed scenarios plus randomized traffic, every
// cycle compared against a behavioural model of the shadow bank.
module tb_ss_reg_bank;

    localparam int          BASE = 16;
    localparam int          N    = 4;
    localparam logic [255:0] DEFS = {64'h7FFF, 64'hA5, 64'h0, 64'h0123_4567_89AB_CDEF};

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [63:0]  ss_din = '0;
    logic [9:0]   ss_adr = '0;
    logic         ss_wren = 1'b0;
    logic         ss_rst = 1'b0;
    logic [63:0]  ss_dout;
    logic [255:0] live_in = '0;
    logic         capture = 1'b0;
    logic         commit = 1'b0;
    logic         busy;
    logic         load_valid;
    logic [3:0]   load_idx;
    logic [63:0]  load_data;

    ss_reg_bank #(
        .BASE_INDEX (10'd16),
        .NUM_REGS   (4),
        .DEFAULTS   (DEFS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ss_din     (ss_din),
        .ss_adr     (ss_adr),
        .ss_wren    (ss_wren),
        .ss_rst     (ss_rst),
        .ss_dout    (ss_dout),
        .live_in    (live_in),
        .capture    (capture),
        .commit     (commit),
        .busy       (busy),
        .load_valid (load_valid),
        .load_idx   (load_idx),
        .load_data  (load_data)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: register contents, pending-apply flags, commit walk position.
    logic [63:0] m_shadow [N];
    bit          m_dirty  [N];
    bit          m_busy;
    int          m_cursor;
    logic [63:0] e_dout;
    logic        e_lv;
    int          e_idx;
    logic [63:0] e_data;

    logic [63:0] em_data [$];
    int          em_idx  [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] def_of(input int i);
        logic [255:0] d;
        d = DEFS;
        return d[i*64 +: 64];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_shadow[i] = def_of(i);
            m_dirty[i]  = 1'b0;
        end
        m_busy   = 1'b0;
        m_cursor = 0;
    endfunction

    // One clock of the bank as described: read old contents, walk the commit,
    // then apply reset / snapshot / write in priority order.
    function automatic void model_edge();
        bit hit;
        int li;
        int j;
        hit    = (int'(ss_adr) >= BASE) && (int'(ss_adr) < BASE + N);
        li     = int'(ss_adr) - BASE;
        e_dout = hit ? m_shadow[li] : 64'h0;
        e_lv   = 1'b0;
        if (m_busy) begin
            j = -1;
            for (int k = m_cursor; k < N; k++) begin
                if (m_dirty[k]) begin
                    j = k;
                    break;
                end
            end
            if (j >= 0) begin
                e_lv       = 1'b1;
                e_idx      = j;
                e_data     = m_shadow[j];
                m_dirty[j] = 1'b0;
                m_cursor   = j + 1;
            end else begin
                m_busy = 1'b0;
            end
        end else if (commit) begin
            m_busy   = 1'b1;
            m_cursor = 0;
        end
        if (ss_rst) begin
            for (int i = 0; i < N; i++) begin
                m_shadow[i] = def_of(i);
                m_dirty[i]  = 1'b1;
            end
        end else if (capture) begin
            for (int i = 0; i < N; i++) m_shadow[i] = live_in[i*64 +: 64];
        end else if (ss_wren && hit) begin
            m_shadow[li] = ss_din;
            m_dirty[li]  = 1'b1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("dout", ss_dout, e_dout);
        chk("busy", 64'(busy), 64'(m_busy));
        chk("load_valid", 64'(load_valid), 64'(e_lv));
        if (e_lv) begin
            chk("load_idx", 64'(load_idx), 64'(e_idx));
            chk("load_data", load_data, e_data);
        end
        if (load_valid) begin
            em_idx.push_back(int'(load_idx));
            em_data.push_back(load_data);
        end
    endtask

    task automatic idle_inputs();
        ss_wren = 1'b0;
        ss_rst  = 1'b0;
        capture = 1'b0;
        commit  = 1'b0;
    endtask

    // Asserts reset away from any clock edge and checks outputs clear at once.
    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        #2;
        chk("rst_dout", ss_dout, 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_lv", 64'(load_valid), 64'h0);
        chk("rst_idx", 64'(load_idx), 64'h0);
        chk("rst_data", load_data, 64'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Pulses commit and runs until busy drops; returns how long busy was high.
    task automatic run_commit(output int busy_cycles);
        em_idx.delete();
        em_data.delete();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        busy_cycles = 0;
        while (busy && busy_cycles < 40) begin
            busy_cycles++;
            tick();
        end
        if (busy_cycles >= 40) chk("commit_timeout", 64'(busy), 64'h0);
    endtask

    task automatic write_reg(input int adr, input logic [63:0] val);
        ss_adr  = 10'(adr);
        ss_din  = val;
        ss_wren = 1'b1;
        tick();
        ss_wren = 1'b0;
    endtask

    int bc;

    initial begin
        #2;
        do_reset();

        // Default readback and out-of-window read.
        ss_adr = 10'd19;
        tick();
        chk("t1_rd19", ss_dout, 64'h7FFF);
        ss_adr = 10'd20;
        tick();
        chk("t1_rd20", ss_dout, 64'h0);

        // Single dirty register streamed.
        write_reg(17, 64'hDEAD_BEEF);
        run_commit(bc);
        chk("t2_busy_cycles", 64'(bc), 64'd2);
        chk("t2_count", 64'(em_idx.size()), 64'd1);
        if (em_idx.size() == 1) begin
            chk("t2_idx", 64'(em_idx[0]), 64'd1);
            chk("t2_data", em_data[0], 64'hDEAD_BEEF);
        end

        // Savestate reset marks everything dirty with defaults.
        ss_rst = 1'b1;
        tick();
        ss_rst = 1'b0;
        run_commit(bc);
        chk("t3_busy_cycles", 64'(bc), 64'd5);
        chk("t3_count", 64'(em_idx.size()), 64'd4);
        if (em_idx.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t3_idx", 64'(em_idx[i]), 64'(i));
                chk("t3_data", em_data[i], def_of(i));
            end
        end

        // Snapshot updates shadow but leaves nothing to apply.
        live_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        live_in[128 +: 64] = 64'h1234;
        capture = 1'b1;
        tick();
        capture = 1'b0;
        ss_adr = 10'd18;
        tick();
        chk("t4_rd18", ss_dout, 64'h1234);
        run_commit(bc);
        chk("t4_busy_cycles", 64'(bc), 64'd1);
        chk("t4_count", 64'(em_idx.size()), 64'd0);

        // Writes during a scan: above cursor joins this scan, below waits.
        for (int i = 0; i < 4; i++) write_reg(BASE + i, 64'(100 + i));
        em_idx.delete();
        em_data.delete();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        tick();
        ss_adr = 10'd19; ss_din = 64'd9; ss_wren = 1'b1;
        tick();
        ss_adr = 10'd16; ss_din = 64'd5;
        tick();
        ss_wren = 1'b0;
        tick();
        chk("t5_busy_end", 64'(busy), 64'h0);
        chk("t5_count", 64'(em_idx.size()), 64'd4);
        if (em_idx.size() == 4) begin
            chk("t5_data2", em_data[2], 64'd102);
            chk("t5_idx3", 64'(em_idx[3]), 64'd3);
            chk("t5_data3", em_data[3], 64'd9);
        end
        run_commit(bc);
        chk("t5b_count", 64'(em_idx.size()), 64'd1);
        if (em_idx.size() == 1) begin
            chk("t5b_idx", 64'(em_idx[0]), 64'd0);
            chk("t5b_data", em_data[0], 64'd5);
        end

        // Reset while a load is in flight.
        ss_rst = 1'b1;
        ss_adr = 10'd19;
        tick();
        ss_rst = 1'b0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        chk("t6_lv_before", 64'(load_valid), 64'h1);
        chk("t6_dout_before", ss_dout, 64'h7FFF);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ss_adr = 10'(BASE + i);
            tick();
            chk("t6_default", ss_dout, def_of(i));
        end

        // Randomized traffic against the model.
        for (int it = 0; it < 800; it++) begin
            if (it == 400) do_reset();
            ss_adr  = 10'(14 + $urandom_range(0, 7));
            ss_din  = {$urandom, $urandom};
            ss_wren = ($urandom_range(0, 2) == 0);
            ss_rst  = ($urandom_range(0, 39) == 0);
            capture = ($urandom_range(0, 29) == 0);
            commit  = ($urandom_range(0, 7) == 0);
            live_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 8; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ss_reg_bank.md
Name: ss_reg_bank

Overview:
Parametrised savestate register bank: one savestate-bus slave serving NUM_REGS consecutive 64-bit indices from BASE_INDEX.
- Holds a shadow copy per register.
- Captures live core state on request.
- Accepts bus writes, reloads per-register defaults on savestate reset, and reads back onto the OR-combined bus.
- On commit, streams only dirty registers, one per cycle, to the owning core module.
- Replaces per-module single-register savestate glue in CPU/PPU/APU/mapper blocks.

Parameters:
- BASE_INDEX, 10'd0, first savestate index served.
- NUM_REGS, 4, registers in bank (1..16).
- DEFAULTS, all zeros, NUM_REGS*64-bit flat vector; register i is bits [64*i+63:64*i].

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ss_din  in  64  savestate bus write data
- ss_adr  in  10  savestate bus index
- ss_wren  in  1  bus write strobe
- ss_rst  in  1  savestate reset: shadow <= DEFAULTS
- ss_dout  out  64  registered read data, zero when not addressed
- live_in  in  NUM_REGS*64  current core state
- capture  in  1  snapshot pulse: shadow <= live_in
- commit  in  1  start streaming dirty shadow registers to core
- busy  out  1  commit scan in progress
- load_valid  out  1  load_idx/load_data valid this cycle
- load_idx  out  4  register number within bank
- load_data  out  64  value to apply

Behaviour:
Reset (reset_n low, asynchronous):
- shadow = DEFAULTS; dirty = 0; state IDLE.
- ss_dout = 0; busy = 0; load_valid = 0; load_idx = 0; load_data = 0.

Address decode:
- hit when BASE_INDEX <= ss_adr < BASE_INDEX+NUM_REGS.
- local index = ss_adr - BASE_INDEX, computed 10-bit, truncated to 4 bits.

Read path:
- ss_dout <= hit ? shadow[local] : 0. Latency 1 cycle.
- Reflects shadow state at the start of that cycle; a same-cycle write is not forwarded.

Shadow update priority per register, evaluated each cycle:
1. ss_rst: all shadow <= DEFAULTS, all dirty <= 1.
2. capture: all shadow <= live_in. Dirty is unchanged, because a snapshot is not applied back.
3. ss_wren && hit: shadow[local] <= ss_din; dirty[local] <= 1.
- ss_wren is ignored when ss_rst or capture is high.

Commit state machine, states IDLE and SCAN:
- IDLE, commit=1: cursor <= 0, busy <= 1, go to SCAN. commit while busy is ignored.
- SCAN: find the lowest dirty index j >= cursor.
  - If found: next cycle load_valid=1, load_idx=j, load_data=shadow[j]; dirty[j] <= 0; cursor <= j+1.
  - If none found: busy <= 0, go to IDLE; no load_valid that cycle.
- Throughput is one dirty register per cycle. A commit with no dirty registers takes 1 cycle in SCAN.
- A write during SCAN to an index >= cursor is picked up by this scan, with the new value.
- A write during SCAN to an index < cursor stays dirty for the next commit.
- Same-cycle write and emit on the same index: the old value is emitted, and dirty is set again by the write.
- ss_rst during SCAN: the scan continues from the cursor and emits defaults for the remaining indices. Indices below the cursor stay dirty.
- Index arithmetic: cursor is 5 bits; cursor == NUM_REGS means none remaining.
- Reset mid-SCAN: immediate return to IDLE, all outputs cleared.

Decomposition:
Package ss_bus_pkg holds:
- SS_ADR_W = 10 and SS_DATA_W = 64.
- typedef ss_word_t.
- Helper function ss_hit(adr, base, n).
- Existing SSREG_INDEX_* constants stay where they are; banks are instantiated with BASE_INDEX set from them.

Sub-module ss_dirty_scan:
- Combinational priority encoder: (dirty mask, cursor) -> found, index.
- Kept separate so NUM_REGS scaling is isolated and unit-testable.

Test Plan:
1. Reset with BASE_INDEX=16, NUM_REGS=4, DEFAULTS reg3=64'h7FFF, then read adr 19 -> ss_dout=64'h7FFF one cycle later. Read adr 20 -> 0.
2. Write adr 17 = 64'hDEAD_BEEF, then commit -> single load_valid with idx=1, data=64'hDEADBEEF; busy high 2 cycles total.
3. ss_rst then commit -> 4 consecutive load_valid cycles, idx 0..3, data = DEFAULTS; busy drops the cycle after idx=3.
4. live_in reg2=64'h1234 with capture, then read adr 18 -> 64'h1234. A subsequent commit emits nothing, with busy high 1 cycle.
5. During SCAN at cursor=2 (regs 0..3 dirty), write reg0=5 and reg3=9 -> this scan emits reg3=9; the next commit emits only reg0=5.
6. Assert reset_n low while load_valid is high -> busy, load_valid and ss_dout are 0 immediately with no clock edge; shadow equals DEFAULTS.
